// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: host-side bundle for the multiplexed seven-segment driver.
// Optional feature macro: SEG_BLINK_EN adds the blink_in capture vector.
//
// Handshake: load is a one-cycle strobe with no ready. The driver accepts
// digits_in/blank_in/dp_in (and blink_in) on every rising clk edge where
// load is 1, so the host must hold the data valid for that edge only.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   dp_in;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_in;
`endif
    logic                    load;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_done;

    // Host side: drives the display data and the load strobe.
    modport master (
        output digits_in, blank_in, dp_in,
`ifdef SEG_BLINK_EN
        output blink_in,
`endif
        output load,
        input  an_n, seg_n, dp_n, frame_done
    );

    // Driver side: consumes the display data, drives the pins.
    modport slave (
        input  digits_in, blank_in, dp_in,
`ifdef SEG_BLINK_EN
        input  blink_in,
`endif
        input  load,
        output an_n, seg_n, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed hex display driver with an anti-ghost
// guard slot, double-buffered display data and frame-aligned updates.
// Optional feature macro: SEG_BLINK_EN (per-digit blinking, phase toggles
// every BLINK_DIV frames).
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCNT_W = $clog2(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Reject out-of-range configurations at elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (PRESCALE < 2 || PRESCALE > (1 << 20)) begin : g_bad_prescale
        $error("seg_scan_driver: PRESCALE must be 2..2^20");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg_scan_driver: BLINK_DIV must be at least 1");
    end

    logic [PCNT_W-1:0]       pcnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_end;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] dig_act,   dig_pend;
    logic [NUM_DIGITS-1:0]   blank_act, blank_pend;
    logic [NUM_DIGITS-1:0]   dp_act,    dp_pend;
    logic                    pend;

    logic [3:0]              nib;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Slot and frame boundaries; a frame ends when the last digit's slot ends.
    assign slot_end = (pcnt == PCNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Prescaler and digit index: idx steps once per PRESCALE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Double buffer: loads park in the pending copy; the active copy only
    // changes on a frame wrap so one frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_act    <= '0;
            blank_act  <= '0;
            dp_act     <= '0;
            dig_pend   <= '0;
            blank_pend <= '0;
            dp_pend    <= '0;
            pend       <= 1'b0;
        end else if (wrap) begin
            if (bus.load) begin
                dig_act   <= bus.digits_in;
                blank_act <= bus.blank_in;
                dp_act    <= bus.dp_in;
            end else if (pend) begin
                dig_act   <= dig_pend;
                blank_act <= blank_pend;
                dp_act    <= dp_pend;
            end
            pend <= 1'b0;
        end else if (bus.load) begin
            dig_pend   <= bus.digits_in;
            blank_pend <= bus.blank_in;
            dp_pend    <= bus.dp_in;
            pend       <= 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0] blink_act, blink_pend;
    logic [FCNT_W-1:0]     fcnt;
    logic                  phase;

    // Blink mask follows the same pending/active rules as blank_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_act  <= '0;
            blink_pend <= '0;
        end else if (wrap) begin
            if (bus.load) begin
                blink_act <= bus.blink_in;
            end else if (pend) begin
                blink_act <= blink_pend;
            end
        end else if (bus.load) begin
            blink_pend <= bus.blink_in;
        end
    end

    // Frame counter; phase flips every BLINK_DIV frames, 0 = digits on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FCNT_LAST) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Current digit is dark when blanked, or blinking during the off phase.
    always_comb begin
        dark = blank_act[idx] | (phase & blink_act[idx]);
    end
`else
    // Current digit is dark when blanked.
    always_comb begin
        dark = blank_act[idx];
    end
`endif

    // Next pin values: anodes stay off in the first cycle of each slot so the
    // previous digit's segments never ghost onto the new anode.
    always_comb begin
        nib      = dig_act[4*idx +: 4];
        seg_next = dark ? 7'b1111111 : hex7(nib);
        dp_next  = dark ? 1'b1 : ~dp_act[idx];
        an_next  = (pcnt == '0) ? '1 : ~(NUM_DIGITS'(1) << idx);
    end

    // Output registers: all pins share one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an_n       <= '1;
            bus.seg_n      <= 7'b1111111;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an_n       <= an_next;
            bus.seg_n      <= seg_next;
            bus.dp_n       <= dp_next;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver with
// NUM_DIGITS=4, PRESCALE=4, BLINK_DIV=2 (16 cycles per frame).
// Optional feature macro: SEG_BLINK_EN enables the blink steps.
module tb_seg_scan_driver;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    seg_scan_driver_if #(.NUM_DIGITS(4)) bus();

    seg_scan_driver #(
        .NUM_DIGITS(4),
        .PRESCALE  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string where);
        chk({where, "_an_n"},  bus.an_n, 16'h000F);
        chk({where, "_seg_n"}, bus.seg_n, 16'h007F);
        chk({where, "_dp_n"},  bus.dp_n, 16'h0001);
        chk({where, "_fdone"}, bus.frame_done, 16'h0000);
    endtask

    // Runs from a frame start for `steps` cycles. Expected seg per digit
    // s0..s3 and dp_n per digit dpn; optional loads at steps la and lb.
    task automatic check_frame(input logic [6:0] s0, s1, s2, s3,
                               input logic [3:0] dpn, input int steps,
                               input int la, input logic [15:0] da,
                               input int lb, input logic [15:0] db,
                               input logic [3:0] bl, input logic [3:0] dpv);
        logic [6:0] s [4];
        logic [3:0] e_an;
        int d;
        int ph;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int j = 1; j <= steps; j++) begin
            if (j == la) begin
                bus.digits_in = da; bus.blank_in = bl; bus.dp_in = dpv; bus.load = 1'b1;
            end else if (j == lb) begin
                bus.digits_in = db; bus.blank_in = bl; bus.dp_in = dpv; bus.load = 1'b1;
            end
            @(posedge clk); #1;
            bus.load = 1'b0;
            d  = (j - 1) / 4;
            ph = (j - 1) % 4;
            if (ph == 0) begin
                chk("an_guard", bus.an_n, 16'h000F);
            end else begin
                e_an = ~(4'b0001 << d);
                chk("an_lit", bus.an_n, e_an);
                chk("seg_n", bus.seg_n, s[d]);
                chk("dp_n", bus.dp_n, dpn[d]);
            end
            chk("frame_done", bus.frame_done, (j == 16));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.blank_in  = '0;
        bus.dp_in     = '0;
`ifdef SEG_BLINK_EN
        bus.blink_in  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        chk("release_an_n", bus.an_n, 16'h000F);

        // Frame 0: all zeros; mid-frame load of A5F3 must not disturb it.
        check_frame(S0, S0, S0, S0, 4'hF, 16, 6, 16'hA5F3, 0, 16'h0, 4'h0, 4'h0);
        // Frame 1: A5F3; a load on the wrap edge goes straight to the next frame.
        check_frame(S3, SF, S5, SA, 4'hF, 16, 16, 16'h1234, 0, 16'h0, 4'h0, 4'h0);
        // Frame 2: 1234; two loads inside the frame, the later one wins.
        check_frame(S4, S3, S2, S1, 4'hF, 16, 3, 16'h1111, 9, 16'h2222, 4'h0, 4'h0);
        // Frame 3: 2222; load 8888 with digit 2 blanked and digit 0 dp lit.
        check_frame(S2, S2, S2, S2, 4'hF, 16, 5, 16'h8888, 0, 16'h0, 4'b0100, 4'b0001);
        // Frame 4 (partial): blank/dp frame, with a pending 7777 load.
        check_frame(S8, S8, SB, S8, 4'b1110, 6, 2, 16'h7777, 0, 16'h0, 4'h0, 4'h0);

        // Asynchronous reset mid-slot: pins clear without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk); #1;
        chk_reset_vals("reset_hold");
        rst_n = 1'b1;

        // The discarded 7777 must never appear in the next two frames.
        check_frame(S0, S0, S0, S0, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
`ifdef SEG_BLINK_EN
        bus.blink_in = 4'b1000;
`endif
        check_frame(S0, S0, S0, S0, 4'hF, 16, 16, 16'h0000, 0, 16'h0, 4'h0, 4'h0);
`ifdef SEG_BLINK_EN
        // Phase goes off for frames 2-3, back on for frames 4-5.
        check_frame(S0, S0, S0, SB, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
        check_frame(S0, S0, S0, SB, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
        check_frame(S0, S0, S0, S0, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
        check_frame(S0, S0, S0, S0, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
        check_frame(S0, S0, S0, SB, 4'hF, 16, 0, 16'h0, 0, 16'h0, 4'h0, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
